// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, majority-vote bit sampling, configurable
// frame format with parity/framing flags, and a first-word-fall-through output FIFO.
module uart_rx_param #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int unsigned BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned MID     = BPS_CNT / 2;
    localparam int unsigned CNT_W   = $clog2(BPS_CNT);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned EW      = DATA_BITS + 2;
    localparam logic        STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // Synchroniser and edge-detect history, all held at the idle (high) level on reset.
    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           bit_q;
    logic                 stop_q;
    logic                 samp_a_q, samp_b_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_err_q;
    logic                 frame_err_q;

    logic          at_mid_m1, at_mid, at_dec, cnt_last;
    logic          vote;
    logic          frame_done;
    logic [EW-1:0] push_entry;

    always_comb begin
        at_mid_m1  = (cnt_q == CNT_W'(MID - 1));
        at_mid     = (cnt_q == CNT_W'(MID));
        at_dec     = (cnt_q == CNT_W'(MID + 1));
        cnt_last   = (cnt_q == CNT_W'(BPS_CNT - 1));
        // Third sample is the live synced line at the decision point.
        vote       = (samp_a_q & samp_b_q) | (samp_a_q & rxd_sync_q) | (samp_b_q & rxd_sync_q);
        frame_done = (state_q == StStop) && at_dec && (stop_q == STOP_LAST);
        push_entry = {shift_q, par_err_q, frame_err_q | ~vote};
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            stop_q      <= 1'b0;
            samp_a_q    <= 1'b1;
            samp_b_q    <= 1'b1;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (state_q != StIdle) begin
                cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                if (at_mid_m1) begin
                    samp_a_q <= rxd_sync_q;
                end
                if (at_mid) begin
                    samp_b_q <= rxd_sync_q;
                end
            end
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (rxd_prev_q && !rxd_sync_q) begin
                        state_q     <= StStart;
                        bit_q       <= '0;
                        stop_q      <= 1'b0;
                        par_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (at_dec) begin
                        state_q <= vote ? StIdle : StData;
                    end
                end
                StData: begin
                    if (at_dec) begin
                        shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? StParity : StStop;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (at_dec) begin
                        par_err_q <= ((^shift_q) ^ vote) != (PARITY == 1);
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (at_dec) begin
                        frame_err_q <= frame_err_q | ~vote;
                        // Leave at mid-stop so a start edge late in the stop bit is caught.
                        if (stop_q == STOP_LAST) begin
                            state_q <= StIdle;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output FIFO; pointers carry one extra wrap bit to tell full from empty.
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          overrun_q;
    logic          empty, full, pop, push_ok;
    logic [EW-1:0] head;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop     = !empty && rx_ready;
        push_ok = frame_done && (!full || pop);
        head    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge I_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_q + {{AW{1'b0}}, push_ok};
            rd_ptr_q  <= rd_ptr_q + {{AW{1'b0}}, pop};
            overrun_q <= frame_done && full && !pop;
        end
    end

    always_comb begin
        rx_valid   = !empty;
        rx_overrun = overrun_q;
        rx_busy    = (state_q != StIdle);
        if (empty) begin
            {rx_data, rx_parity_err, rx_frame_err} = '0;
        end else begin
            {rx_data, rx_parity_err, rx_frame_err} = head;
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three instances cover 8N1, 7E1 and 8N2 framing
// at BPS_CNT=10.
module tb_uart_rx_param;

    localparam int BIT = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_a = 1'b1, rxd_b = 1'b1, rxd_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b0, ready_c = 1'b0;

    logic [7:0] data_a, data_c;
    logic [6:0] data_b;
    logic perr_a, ferr_a, valid_a, ovr_a, busy_a;
    logic perr_b, ferr_b, valid_b, ovr_b, busy_b;
    logic perr_c, ferr_c, valid_c, ovr_c, busy_c;

    int checks = 0;
    int failures = 0;
    int ovr_cnt_a = 0;

    logic [10:0] q_a[$];
    logic [10:0] q_b[$];
    logic [10:0] q_c[$];

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(100), .UART_BPS(10)) u_a (
        .I_clk(clk), .I_rst(rst), .uart_rxd(rxd_a), .rx_data(data_a),
        .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .rx_overrun(ovr_a), .rx_busy(busy_a)
    );

    uart_rx_param #(.CLK_FREQ(100), .UART_BPS(10), .DATA_BITS(7), .PARITY(2)) u_b (
        .I_clk(clk), .I_rst(rst), .uart_rxd(rxd_b), .rx_data(data_b),
        .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .rx_overrun(ovr_b), .rx_busy(busy_b)
    );

    uart_rx_param #(.CLK_FREQ(100), .UART_BPS(10), .STOP_BITS(2)) u_c (
        .I_clk(clk), .I_rst(rst), .uart_rxd(rxd_c), .rx_data(data_c),
        .rx_parity_err(perr_c), .rx_frame_err(ferr_c), .rx_valid(valid_c),
        .rx_ready(ready_c), .rx_overrun(ovr_c), .rx_busy(busy_c)
    );

    // Build an LSB-first frame: start, data, optional parity, stop bits.
    function automatic logic [15:0] mk_frame(input logic [8:0] d, input int nd,
                                             input int use_par, input logic par,
                                             input logic [1:0] stops, input int nstop,
                                             output int n);
        logic [15:0] f;
        int p;
        f = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            f[p] = d[i];
            p++;
        end
        if (use_par != 0) begin
            f[p] = par;
            p++;
        end
        for (int s = 0; s < nstop; s++) begin
            f[p] = stops[s];
            p++;
        end
        n = p;
        return f;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            if (ovr_a) ovr_cnt_a++;
        end
    endtask

    task automatic set_line(input int inst, input logic v);
        case (inst)
            0: rxd_a = v;
            1: rxd_b = v;
            default: rxd_c = v;
        endcase
    endtask

    task automatic drive_line(input int inst, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_line(inst, bits[i]);
            step(BIT);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(3);
        checks++;
        if (valid_a !== 1'b0 || valid_b !== 1'b0 || valid_c !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b%b%b exp=000", valid_a, valid_b, valid_c);
        end
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b%b%b exp=000", busy_a, busy_b, busy_c);
        end
        checks++;
        if ({data_a, perr_a, ferr_a, ovr_a} !== 11'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {data_a, perr_a, ferr_a, ovr_a});
        end
        rst = 1'b0;
        step(5);
    endtask

    task automatic test_8n1;
        logic [15:0] f;
        logic [10:0] exp;
        int n;
        ready_a = 1'b1;
        q_a.push_back({1'b0, 8'hA5, 1'b0, 1'b0});
        f = mk_frame(9'h0A5, 8, 0, 1'b0, 2'b01, 1, n);
        drive_line(0, f, n - 1);
        rxd_a = 1'b1;
        step(BIT - 1);
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL 8n1_valid_early got=%b exp=0", valid_a);
        end
        step(1);
        checks++;
        if (valid_a !== 1'b1) begin
            failures++;
            $display("FAIL 8n1_valid_on_time got=%b exp=1", valid_a);
        end
        exp = q_a.pop_front();
        checks++;
        if ({1'b0, data_a, perr_a, ferr_a} !== exp) begin
            failures++;
            $display("FAIL 8n1_frame got=%h exp=%h", {1'b0, data_a, perr_a, ferr_a}, exp);
        end
        step(1);
        checks++;
        if (valid_a !== 1'b0) begin
            failures++;
            $display("FAIL 8n1_single_valid got=%b exp=0", valid_a);
        end
        step(20);
    endtask

    task automatic test_parity;
        logic [15:0] f;
        logic [10:0] exp;
        logic [6:0] d;
        logic par;
        int n;
        int t;
        d = 7'h03;
        for (int k = 0; k < 2; k++) begin
            par = (k == 0) ? 1'b1 : 1'b0;
            // Even parity: the correct parity bit equals the XOR of the data bits.
            q_b.push_back({2'b00, d, par ^ (^d), 1'b0});
            f = mk_frame({2'b00, d}, 7, 1, par, 2'b01, 1, n);
            drive_line(1, f, n);
            t = 0;
            while (!valid_b && t < 300) begin
                step(1);
                t++;
            end
            checks++;
            if (valid_b !== 1'b1) begin
                failures++;
                $display("FAIL parity_valid_timeout got=%b exp=1", valid_b);
            end
            exp = q_b.pop_front();
            checks++;
            if ({2'b00, data_b, perr_b, ferr_b} !== exp) begin
                failures++;
                $display("FAIL parity_frame%0d got=%h exp=%h", k,
                         {2'b00, data_b, perr_b, ferr_b}, exp);
            end
            ready_b = 1'b1;
            step(1);
            ready_b = 1'b0;
            step(20);
        end
    endtask

    task automatic test_stop2;
        logic [15:0] f;
        logic [10:0] exp;
        logic [7:0] d;
        logic [1:0] stops;
        int n;
        int t;
        for (int k = 0; k < 2; k++) begin
            d = (k == 0) ? 8'h5A : 8'h11;
            stops = (k == 0) ? 2'b01 : 2'b11;
            q_c.push_back({1'b0, d, 1'b0, ~stops[1]});
            f = mk_frame({1'b0, d}, 8, 0, 1'b0, stops, 2, n);
            drive_line(2, f, n);
            rxd_c = 1'b1;
            t = 0;
            while (!valid_c && t < 300) begin
                step(1);
                t++;
            end
            checks++;
            if (valid_c !== 1'b1) begin
                failures++;
                $display("FAIL stop2_valid_timeout got=%b exp=1", valid_c);
            end
            exp = q_c.pop_front();
            checks++;
            if ({1'b0, data_c, perr_c, ferr_c} !== exp) begin
                failures++;
                $display("FAIL stop2_frame%0d got=%h exp=%h", k,
                         {1'b0, data_c, perr_c, ferr_c}, exp);
            end
            ready_c = 1'b1;
            step(1);
            ready_c = 1'b0;
            step(30);
        end
    endtask

    task automatic test_glitch;
        int busy_cnt;
        int valid_seen;
        busy_cnt = 0;
        valid_seen = 0;
        rxd_a = 1'b0;
        step(3);
        rxd_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (busy_a) busy_cnt++;
            if (valid_a) valid_seen++;
            step(1);
        end
        // START occupies counter values 0..MID+1 before rejecting the false start.
        checks++;
        if (busy_cnt != 7) begin
            failures++;
            $display("FAIL glitch_busy_cycles got=%0d exp=7", busy_cnt);
        end
        checks++;
        if (valid_seen != 0) begin
            failures++;
            $display("FAIL glitch_no_push got=%0d exp=0", valid_seen);
        end
    endtask

    task automatic test_overrun;
        logic [15:0] f;
        logic [10:0] exp;
        int n;
        ready_a = 1'b0;
        ovr_cnt_a = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) q_a.push_back({1'b0, 8'(k), 1'b0, 1'b0});
            f = mk_frame(9'(k), 8, 0, 1'b0, 2'b01, 1, n);
            drive_line(0, f, n);
            step(BIT);
            if (k == 4) begin
                checks++;
                if (ovr_cnt_a != 0) begin
                    failures++;
                    $display("FAIL overrun_early got=%0d exp=0", ovr_cnt_a);
                end
            end
        end
        checks++;
        if (ovr_cnt_a != 1) begin
            failures++;
            $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt_a);
        end
        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid_a !== 1'b1) begin
                failures++;
                $display("FAIL drain_valid%0d got=%b exp=1", i, valid_a);
            end
            exp = (q_a.size() != 0) ? q_a.pop_front() : 11'h7FF;
            checks++;
            if ({1'b0, data_a, perr_a, ferr_a} !== exp) begin
                failures++;
                $display("FAIL drain_frame%0d got=%h exp=%h", i,
                         {1'b0, data_a, perr_a, ferr_a}, exp);
            end
            step(1);
        end
        checks++;
        if (valid_a !== 1'b0 || data_a !== 8'h00) begin
            failures++;
            $display("FAIL drain_empty got=%b/%h exp=0/00", valid_a, data_a);
        end
        step(10);
    endtask

    task automatic test_reset_mid;
        logic [15:0] f;
        logic [10:0] exp;
        int n;
        int t;
        ready_a = 1'b1;
        f = mk_frame(9'h077, 8, 0, 1'b0, 2'b01, 1, n);
        drive_line(0, f, 4);
        checks++;
        if (busy_a !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy got=%b exp=1", busy_a);
        end
        rst = 1'b1;
        step(1);
        rxd_a = 1'b1;
        checks++;
        if ({data_a, perr_a, ferr_a, valid_a, ovr_a, busy_a} !== 13'h0) begin
            failures++;
            $display("FAIL midframe_reset got=%h exp=0",
                     {data_a, perr_a, ferr_a, valid_a, ovr_a, busy_a});
        end
        step(2);
        rst = 1'b0;
        step(10);
        q_a.push_back({1'b0, 8'h3C, 1'b0, 1'b0});
        f = mk_frame(9'h03C, 8, 0, 1'b0, 2'b01, 1, n);
        drive_line(0, f, n);
        t = 0;
        while (!valid_a && t < 300) begin
            step(1);
            t++;
        end
        checks++;
        if (valid_a !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_valid got=%b exp=1", valid_a);
        end
        exp = q_a.pop_front();
        checks++;
        if ({1'b0, data_a, perr_a, ferr_a} !== exp) begin
            failures++;
            $display("FAIL after_reset_frame got=%h exp=%h",
                     {1'b0, data_a, perr_a, ferr_a}, exp);
        end
        step(10);
    endtask

    initial begin
        step(1);
        test_reset;
        test_8n1;
        test_parity;
        test_stop2;
        test_glitch;
        test_overrun;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
